// File: rtl/wptr_full_lvl_if.sv
// Write-side FIFO pointer/status bundle: the write request and read-pointer inputs
// going into the pointer block, and the memory strobe and status flags coming back.
interface wptr_full_lvl_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE:0]   wafull_thr;
  logic                wovf_clr;
  logic                wen;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                wafull;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  // Writer side: drives requests and the synchronised read pointer, observes status
  modport master (
    output winc, wq2_rptr, wafull_thr, wovf_clr,
    input  wen, waddr, wptr, wfull, wafull, wlevel, wovf
  );

  // Pointer block side: consumes requests, produces strobe, pointer and flags
  modport slave (
    input  winc, wq2_rptr, wafull_thr, wovf_clr,
    output wen, waddr, wptr, wfull, wafull, wlevel, wovf
  );
endinterface

// File: rtl/wptr_full_lvl.sv
// Write-domain pointer and status block of a dual-clock Gray-pointer FIFO.
// Keeps the binary/Gray write pointer and derives registered full, almost-full,
// fill level and a sticky overflow flag from the synchronised Gray read pointer.
// Flags are pessimistic: read-side frees arrive late, so full never drops early.
module wptr_full_lvl #(
  parameter int ADDRSIZE = 4
) (
  input  logic          wclk,
  input  logic          wrst,
  wptr_full_lvl_if.slave bus
);

  logic [ADDRSIZE:0] wbin_q,   wbin_d;
  logic [ADDRSIZE:0] wptr_q,   wptr_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              wfull_q,  wfull_d;
  logic              wafull_q, wafull_d;
  logic              wovf_q,   wovf_d;
  logic [ADDRSIZE:0] rbin;
  logic              wen;
  logic              fullByGray;

  // A write is accepted only when the registered full flag is clear
  assign wen = bus.winc & ~wfull_q;

  // Gray-to-binary of the read pointer: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin[i] = ^(bus.wq2_rptr >> i);
    end
  end

  // Next pointer, Gray code, level and flag values seen at the coming edge
  always_comb begin
    wbin_d     = wbin_q + {{ADDRSIZE{1'b0}}, wen};
    wptr_d     = (wbin_d >> 1) ^ wbin_d;
    wlevel_d   = wbin_d - rbin;
    fullByGray = (wptr_d == {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                             bus.wq2_rptr[ADDRSIZE-2:0]});
    wfull_d    = fullByGray;
    wafull_d   = (bus.wafull_thr != '0) && (wlevel_d >= bus.wafull_thr);
  end

  // Sticky overflow: a dropped write sets it, the clear only wins when no new overflow occurs
  always_comb begin
    wovf_d = wovf_q;
    if (bus.winc && wfull_q) begin
      wovf_d = 1'b1;
    end else if (bus.wovf_clr) begin
      wovf_d = 1'b0;
    end
  end

  // Register pointers and status; reset clears everything immediately
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign bus.wen    = wen;
  assign bus.waddr  = wbin_q[ADDRSIZE-1:0];
  assign bus.wptr   = wptr_q;
  assign bus.wfull  = wfull_q;
  assign bus.wafull = wafull_q;
  assign bus.wlevel = wlevel_q;
  assign bus.wovf   = wovf_q;

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Directed bench for wptr_full_lvl (depth 16). A count-based model pushes the
// expected post-edge state into a queue for each driven cycle; it is popped and
// compared after the edge.
module tb_wptr_full_lvl;
  localparam int A = 4;

  logic wclk = 1'b0;
  logic wrst = 1'b1;

  wptr_full_lvl_if #(.ADDRSIZE(A)) bus ();

  wptr_full_lvl #(.ADDRSIZE(A)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus.slave)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    string      tag;
    logic [4:0] wptr;
    logic [3:0] waddr;
    logic [4:0] wlevel;
    logic       wfull;
    logic       wafull;
    logic       wovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   wcnt  = 0;
  int   rcnt  = 0;
  logic mFull = 1'b0;
  logic mOvf  = 1'b0;

  function automatic logic [4:0] toGray(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".wptr"},   bus.wptr,   e.wptr);
      cmp({e.tag, ".waddr"},  bus.waddr,  e.waddr);
      cmp({e.tag, ".wlevel"}, bus.wlevel, e.wlevel);
      cmp({e.tag, ".wfull"},  bus.wfull,  e.wfull);
      cmp({e.tag, ".wafull"}, bus.wafull, e.wafull);
      cmp({e.tag, ".wovf"},   bus.wovf,   e.wovf);
    end
  endtask

  task automatic pushReset(input string tag);
    exp_t e;
    wcnt  = 0;
    rcnt  = 0;
    mFull = 1'b0;
    mOvf  = 1'b0;
    e.tag = tag; e.wptr = '0; e.waddr = '0; e.wlevel = '0;
    e.wfull = 1'b0; e.wafull = 1'b0; e.wovf = 1'b0;
    sb.push_back(e);
  endtask

  // One write-domain cycle: drive just after the falling edge, model, compare after the rising edge
  task automatic applyStimulus(input logic inc, input int rc, input int thr,
                               input logic clr, input string tag);
    exp_t e;
    int   lvl;
    bus.winc       = inc;
    bus.wq2_rptr   = toGray(rc);
    bus.wafull_thr = thr[4:0];
    bus.wovf_clr   = clr;
    #1;
    cmp({tag, ".wen"}, bus.wen, inc & ~mFull);
    mOvf = (inc && mFull) ? 1'b1 : (clr ? 1'b0 : mOvf);
    if (inc && !mFull) wcnt++;
    rcnt  = rc;
    lvl   = wcnt - rcnt;
    mFull = (lvl == 16);
    e.tag    = tag;
    e.wptr   = toGray(wcnt);
    e.waddr  = wcnt[3:0];
    e.wlevel = lvl[4:0];
    e.wfull  = mFull;
    e.wafull = (thr != 0) && (lvl >= thr);
    e.wovf   = mOvf;
    sb.push_back(e);
    @(posedge wclk);
    #1;
    checkOutput();
    @(negedge wclk);
  endtask

  // Asynchronous reset between edges, checked before any rising edge occurs
  task automatic doReset(input string tag);
    wrst     = 1'b1;
    bus.winc = 1'b1;
    #1;
    pushReset(tag);
    checkOutput();
    cmp({tag, ".wen"}, bus.wen, 1'b1);
    bus.winc = 1'b0;
    #1;
    wrst = 1'b0;
    @(negedge wclk);
  endtask

  // The Gray-compare full condition must match the level-based one every cycle
  always @(negedge wclk) begin
    if (wrst === 1'b0) begin
      total++;
      assert (dut.fullByGray === (dut.wlevel_d == 5'd16)) else begin
        bad++;
        $error("FAIL full_equiv: observed gray=%0b expected level_form=%0b",
               dut.fullByGray, (dut.wlevel_d == 5'd16));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.winc       = 1'b1;
    bus.wq2_rptr   = '0;
    bus.wafull_thr = '0;
    bus.wovf_clr   = 1'b0;
    #2;
    pushReset("reset");
    checkOutput();
    cmp("reset.wen", bus.wen, 1'b1);
    bus.winc = 1'b0;
    @(negedge wclk);
    wrst = 1'b0;

    // Fill from reset, no almost-full threshold
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 0, 0, 1'b0, $sformatf("fill%0d", i));
    cmp("fill.wptr_literal", bus.wptr, 5'b11000);

    // Writes while full are dropped and set overflow
    applyStimulus(1'b1, 0, 0, 1'b0, "ovf0");
    applyStimulus(1'b1, 0, 0, 1'b0, "ovf1");
    applyStimulus(1'b1, 0, 0, 1'b1, "ovf_clr_set");
    applyStimulus(1'b0, 0, 0, 1'b1, "ovf_clr");

    // Read-side free becomes visible at the next edge
    applyStimulus(1'b0, 4, 0, 1'b0, "drain");
    applyStimulus(1'b1, 4, 0, 1'b0, "drain_wr");

    // Almost-full threshold and its runtime change
    doReset("rst_af");
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 0, 12, 1'b0, $sformatf("af%0d", i));
    applyStimulus(1'b0, 0, 13, 1'b0, "af_thr13");

    // Advance both pointers together to 31, then wrap and concurrent events
    doReset("rst_wrap");
    for (int i = 1; i <= 31; i++) applyStimulus(1'b1, i, 0, 1'b0, $sformatf("walk%0d", i));
    applyStimulus(1'b1, 32, 0, 1'b0, "wrap");
    cmp("wrap.wptr_literal", bus.wptr, 5'b00000);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32, 0, 1'b0, $sformatf("lvl8_%0d", i));
    applyStimulus(1'b1, 33, 0, 1'b0, "concurrent");

    // Async reset mid-operation at level 10 with overflow set
    doReset("rst_mid");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 0, 0, 1'b0, $sformatf("refill%0d", i));
    applyStimulus(1'b1, 0, 0, 1'b0, "reovf");
    applyStimulus(1'b0, 6, 0, 1'b0, "lvl10");
    doReset("async_rst");
    applyStimulus(1'b1, 0, 0, 1'b0, "post_rst");
    cmp("post_rst.wptr_literal", bus.wptr, 5'b00001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
